// File: rtl/recovery_ctrl_pkg.sv
// Shared types and widths for the pipeline recovery controller.
package recovery_ctrl_pkg;

    // Controller states: normal flow, post-miss RAT restore, serializing wait.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        SERIAL  = 2'd2
    } ctrl_state_t;

    // RECOVER_CYCLES is limited to 1..15, so four bits hold the recovery count.
    localparam int unsigned RCNT_W = 4;

    // Width of the consecutive-backpressure watchdog counter.
    localparam int unsigned SCNT_W = 16;

endpackage

// File: rtl/recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count up while i_inc is high, stick at all-ones, clear on reset or i_clr.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/recovery_ctrl.sv
// Pipeline stall/flush controller: branch-miss recovery, serializing
// instructions and structural backpressure with a stuck watchdog.
module recovery_ctrl #(
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned STALL_LIMIT    = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic branch_miss,
    input  logic serialize_req,
    input  logic rob_empty,
    input  logic iq_full,
    input  logic rob_full,
    output logic stallF,
    output logic stallD,
    output logic stallR,
    output logic stallI,
    output logic stallS,
    output logic stallE,
    output logic stallC,
    output logic flushD,
    output logic flushR,
    output logic flushI,
    output logic flushS,
    output logic flushE,
    output logic flushC,
    output logic busy,
    output logic stuck
);

    import recovery_ctrl_pkg::*;

    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RECOVER_CYCLES);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_d;
    logic [RCNT_W-1:0] r_rcnt;
    logic [RCNT_W-1:0] w_rcnt_d;
    logic [SCNT_W-1:0] w_scnt;
    logic              w_bp;
    logic              w_scnt_clr;

    assign w_bp       = iq_full | rob_full;
    assign w_scnt_clr = ~w_bp | branch_miss;

    sat_counter #(
        .WIDTH (SCNT_W)
    ) u_scnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_bp),
        .i_clr   (w_scnt_clr),
        .o_count (w_scnt)
    );

    // State and recovery-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_d;
            r_rcnt  <= w_rcnt_d;
        end
    end

    // Next state and stall/flush outputs; priority is reset, miss, serialize, bp.
    always_comb begin
        w_state_d = r_state;
        w_rcnt_d  = r_rcnt;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallR    = 1'b0;
        stallI    = 1'b0;
        stallS    = 1'b0;
        stallE    = 1'b0;
        stallC    = 1'b0;
        flushD    = 1'b0;
        flushR    = 1'b0;
        flushI    = 1'b0;
        flushS    = 1'b0;
        flushE    = 1'b0;
        flushC    = 1'b0;

        if (reset || branch_miss) begin
            flushD = 1'b1;
            flushR = 1'b1;
            flushI = 1'b1;
            flushS = 1'b1;
            flushE = 1'b1;
            flushC = 1'b1;
            if (!reset) begin
                w_state_d = RECOVER;
                w_rcnt_d  = RCNT_LOAD;
            end
        end else begin
            unique case (r_state)
                RUN: begin
                    if (serialize_req && !rob_empty) begin
                        stallF    = 1'b1;
                        stallD    = 1'b1;
                        stallR    = 1'b1;
                        flushI    = 1'b1;
                        w_state_d = SERIAL;
                    end else if (!serialize_req && w_bp) begin
                        // Hold the front end; issue onward keeps draining.
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallR = 1'b1;
                        flushI = 1'b1;
                    end
                end
                RECOVER: begin
                    stallR   = 1'b1;
                    flushI   = 1'b1;
                    w_rcnt_d = r_rcnt - 1'b1;
                    // <= rather than == so a stray zero count cannot lock up.
                    if (r_rcnt <= RCNT_W'(1)) begin
                        w_state_d = RUN;
                    end
                end
                SERIAL: begin
                    if (rob_empty) begin
                        w_state_d = RUN;
                    end else begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallR = 1'b1;
                        flushI = 1'b1;
                    end
                end
                default: begin
                    w_state_d = RUN;
                end
            endcase
        end
    end

    assign busy  = ~reset & (r_state != RUN);
    assign stuck = ~reset & (32'(w_scnt) >= STALL_LIMIT);

endmodule

// File: tb/tb_recovery_ctrl.sv
// Scoreboard bench for recovery_ctrl: stimulus queues expected output vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_recovery_ctrl;

    // Output vector: {stallF,D,R,I,S,E,C, flushD,R,I,S,E,C, busy, stuck}
    localparam logic [14:0] O_IDLE = 15'h0000;
    localparam logic [14:0] O_FL   = 15'h00FC; // all flushes, busy=0
    localparam logic [14:0] O_FLB  = 15'h00FE; // all flushes, busy=1
    localparam logic [14:0] O_REC  = 15'h1022; // stallR, flushI, busy
    localparam logic [14:0] O_HOLD = 15'h7020; // stallF/D/R, flushI, busy=0
    localparam logic [14:0] O_SER  = 15'h7022; // stallF/D/R, flushI, busy=1
    localparam logic [14:0] O_SEND = 15'h0002; // SERIAL exit cycle: only busy
    localparam logic [14:0] O_STK  = 15'h0001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic branch_miss = 1'b0;
    logic serialize_req = 1'b0;
    logic rob_empty = 1'b0;
    logic iq_full = 1'b0;
    logic rob_full = 1'b0;
    logic stallF, stallD, stallR, stallI, stallS, stallE, stallC;
    logic flushD, flushR, flushI, flushS, flushE, flushC;
    logic busy, stuck;

    logic [14:0] q_exp[$];
    string       q_name[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    recovery_ctrl #(
        .RECOVER_CYCLES (2),
        .STALL_LIMIT    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_miss   (branch_miss),
        .serialize_req (serialize_req),
        .rob_empty     (rob_empty),
        .iq_full       (iq_full),
        .rob_full      (rob_full),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallR        (stallR),
        .stallI        (stallI),
        .stallS        (stallS),
        .stallE        (stallE),
        .stallC        (stallC),
        .flushD        (flushD),
        .flushR        (flushR),
        .flushI        (flushI),
        .flushS        (flushS),
        .flushE        (flushE),
        .flushC        (flushC),
        .busy          (busy),
        .stuck         (stuck)
    );

    logic [14:0] w_act;
    assign w_act = {stallF, stallD, stallR, stallI, stallS, stallE, stallC,
                    flushD, flushR, flushI, flushS, flushE, flushC, busy, stuck};

    // One cycle of stimulus plus its expected response.
    task automatic step(input string name, input logic rst, input logic bm,
                        input logic ser, input logic robe, input logic iqf,
                        input logic robf, input logic [14:0] exp);
        @(posedge clk);
        #1;
        reset         = rst;
        branch_miss   = bm;
        serialize_req = ser;
        rob_empty     = robe;
        iq_full       = iqf;
        rob_full      = robf;
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        logic [14:0] exp;
        string       name;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                exp  = q_exp.pop_front();
                name = q_name.pop_front();
                checks++;
                if (w_act !== exp) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h at %0t", name, w_act, exp, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, including reset beating a simultaneous miss and serialize.
        step("rst", 1, 0, 0, 0, 0, 0, O_FL);
        step("rst", 1, 0, 0, 0, 0, 0, O_FL);
        step("rst_bm", 1, 1, 1, 0, 0, 0, O_FL);
        for (int i = 0; i < 7; i++) step("idle", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Branch miss in RUN: flush, two RECOVER cycles, back to RUN.
        step("bm_run", 0, 1, 0, 0, 0, 0, O_FL);
        step("rec1", 0, 0, 0, 0, 0, 0, O_REC);
        step("rec2", 0, 0, 0, 0, 0, 0, O_REC);
        step("post_rec", 0, 0, 0, 0, 0, 0, O_IDLE);
        step("post_rec", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Second miss inside RECOVER reloads the count.
        step("bm_a", 0, 1, 0, 0, 0, 0, O_FL);
        step("rec_a", 0, 0, 0, 0, 0, 0, O_REC);
        step("bm_in_rec", 0, 1, 0, 0, 0, 0, O_FLB);
        step("rec_b1", 0, 0, 0, 0, 0, 0, O_REC);
        step("rec_b2", 0, 0, 0, 0, 0, 0, O_REC);
        step("post_rec_b", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Serialize waits five cycles for the ROB to drain.
        step("ser_enter", 0, 0, 1, 0, 0, 0, O_HOLD);
        for (int i = 0; i < 4; i++) step("ser_wait", 0, 0, 1, 0, 0, 0, O_SER);
        step("ser_done", 0, 0, 1, 1, 0, 0, O_SEND);
        step("ser_after", 0, 0, 0, 1, 0, 0, O_IDLE);

        // Serialize with an already empty ROB passes straight through.
        step("ser_empty", 0, 0, 1, 1, 0, 0, O_IDLE);
        step("ser_empty", 0, 0, 1, 1, 0, 0, O_IDLE);
        step("ser_empty_end", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Branch miss interrupts SERIAL.
        step("ser_enter2", 0, 0, 1, 0, 0, 0, O_HOLD);
        step("ser_wait2", 0, 0, 1, 0, 0, 0, O_SER);
        step("ser_bm", 0, 1, 1, 0, 0, 0, O_FLB);
        step("ser_bm_rec1", 0, 0, 0, 0, 0, 0, O_REC);
        step("ser_bm_rec2", 0, 0, 0, 0, 0, 0, O_REC);
        step("ser_bm_after", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Backpressure is ignored in RECOVER.
        step("bm_c", 0, 1, 0, 0, 0, 0, O_FL);
        step("rec_bp", 0, 0, 0, 0, 1, 1, O_REC);
        step("rec_bp", 0, 0, 0, 0, 1, 1, O_REC);
        step("rec_bp_after", 0, 0, 0, 0, 0, 0, O_IDLE);

        // rob_full backpressure in RUN.
        step("bp_rob", 0, 0, 0, 0, 0, 1, O_HOLD);
        step("bp_rob", 0, 0, 0, 0, 0, 1, O_HOLD);
        step("bp_rob_end", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Watchdog: stuck after 8 bp cycles, clears the cycle after bp drops.
        for (int i = 0; i < 8; i++) step("wd_bp", 0, 0, 0, 0, 1, 0, O_HOLD);
        step("wd_hold9", 0, 0, 0, 0, 1, 0, O_HOLD | O_STK);
        step("wd_drop", 0, 0, 0, 0, 0, 0, O_STK);
        step("wd_clear", 0, 0, 0, 0, 0, 0, O_IDLE);

        // A miss clears the watchdog count even with bp still high.
        for (int i = 0; i < 8; i++) step("wd2_bp", 0, 0, 0, 0, 1, 0, O_HOLD);
        step("wd2_bm", 0, 1, 0, 0, 1, 0, O_FL | O_STK);
        step("wd2_rec1", 0, 0, 0, 0, 0, 0, O_REC);
        step("wd2_rec2", 0, 0, 0, 0, 0, 0, O_REC);
        step("wd2_after", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Reset masks stuck and clears the count.
        for (int i = 0; i < 8; i++) step("wd3_bp", 0, 0, 0, 0, 1, 0, O_HOLD);
        step("rst_stuck", 1, 0, 0, 0, 1, 0, O_FL);
        step("rst_stuck_after", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Reset in the middle of SERIAL.
        step("ser_enter3", 0, 0, 1, 0, 0, 0, O_HOLD);
        step("ser_wait3", 0, 0, 1, 0, 0, 0, O_SER);
        step("rst_ser", 1, 0, 1, 0, 0, 0, O_FL);
        step("rst_ser", 1, 0, 1, 0, 0, 0, O_FL);
        step("rst_ser_after", 0, 0, 0, 0, 0, 0, O_IDLE);
        step("rst_ser_after", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Reset in the middle of RECOVER.
        step("bm_d", 0, 1, 0, 0, 0, 0, O_FL);
        step("rec_d", 0, 0, 0, 0, 0, 0, O_REC);
        step("rst_rec", 1, 0, 0, 0, 0, 0, O_FL);
        step("rst_rec_after", 0, 0, 0, 0, 0, 0, O_IDLE);
        step("rst_rec_after", 0, 0, 0, 0, 0, 0, O_IDLE);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
        #1;
        if (q_exp.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recovery_ctrl.md
RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset; clk and reset are the first two ports.
REQ-002 Parameter RECOVER_CYCLES, default 2, sets the number of RECOVER-state cycles after a branch miss (range 1..15).
REQ-003 Parameter STALL_LIMIT, default 1024, sets the consecutive-backpressure count at which stuck asserts.
REQ-004 Port clk, input, 1, the only clock.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port branch_miss, input, 1, ROB redirect request: flush all speculative state this cycle.
REQ-007 Port serialize_req, input, 1, rename stage holds a CSR/mret instruction that must execute with an empty ROB.
REQ-008 Port rob_empty, input, 1, ROB holds no valid entries.
REQ-009 Ports iq_full and rob_full, input, 1 each, structural backpressure from the issue queue and the ROB.
REQ-010 Ports stallF, stallD, stallR, stallI, stallS, stallE, stallC, output, 1 each, hold the pipeline register of that stage.
REQ-011 Ports flushD, flushR, flushI, flushS, flushE, flushC, output, 1 each, clear the pipeline register of that stage to invalid.
REQ-012 Port busy, output, 1, FSM is not in RUN.
REQ-013 Port stuck, output, 1, backpressure has persisted for at least STALL_LIMIT cycles.

Function
REQ-014 The FSM SHALL have three states: RUN, RECOVER and SERIAL; outputs are combinational from the state and inputs.
REQ-015 Event priority SHALL be, highest first: branch_miss, then serialize, then backpressure (bp = iq_full | rob_full).
REQ-016 When branch_miss=1 in any state, the same cycle SHALL assert flushD through flushC, deassert all stalls, load rcnt=RECOVER_CYCLES and go to RECOVER.
REQ-017 RECOVER SHALL assert stallR and flushI (RAT restore, rename blocked, bubble into issue), leave the other stalls and flushes at 0, and decrement rcnt each cycle.
REQ-018 RECOVER SHALL move to RUN in the cycle after the one with rcnt==1, giving exactly RECOVER_CYCLES RECOVER cycles.
REQ-019 In RUN, serialize_req=1 with rob_empty=0 SHALL assert stallF, stallD, stallR and flushI, and move to SERIAL.
REQ-020 In RUN, serialize_req=1 with rob_empty=1 SHALL issue no stall and stay in RUN, so the instruction passes immediately.
REQ-021 SERIAL SHALL hold stallF, stallD, stallR and flushI until a cycle with rob_empty=1; that cycle deasserts all four and returns to RUN.
REQ-022 In RUN with no serialize, bp=1 SHALL assert stallF, stallD, stallR and flushI; stallS, stallE and stallC stay 0 so the back end drains.
REQ-023 In RECOVER and SERIAL, bp SHALL be ignored; the stall set of that state already covers it.
REQ-024 Counter scnt (16 bits, saturating at 0xFFFF) SHALL increment on every cycle with bp=1 and clear on any cycle with bp=0 or branch_miss=1.
REQ-025 stuck SHALL be 1 exactly when scnt >= STALL_LIMIT.
REQ-026 busy SHALL be 1 exactly when state != RUN.
REQ-027 stallE, stallS and stallC SHALL be 0 in all states; they are reserved for a future memory unit.

Reset
REQ-028 While reset=1, the block SHALL assert flushD through flushC, hold all stalls, busy and stuck at 0, and on the next clock set state=RUN, rcnt=0 and scnt=0.
REQ-029 Reset SHALL take precedence over branch_miss and serialize_req in the same cycle; reset mid-RECOVER or mid-SERIAL returns to RUN with no leftover stall.

Structure
REQ-030 The ctrl_state_t enum (RUN, RECOVER, SERIAL) and the width constants SHALL be defined in the common package.
REQ-031 scnt SHALL be built as one sub-module, sat_counter (parameterised width, inc, clr), instanced once.
REQ-032 The stall and flush outputs SHALL connect to the hazard modport signals one for one.

Verification
REQ-033 Branch miss in RUN (default params): branch_miss pulse at cycle 10 -> flushD..C=1 at cycle 10; stallR=1 and flushI=1 at cycles 11-12; busy=0 and all outputs 0 from cycle 13.
REQ-034 Second miss in RECOVER: branch_miss again at cycle 11 -> flushes again at cycle 11, rcnt reloads, and RECOVER lasts through cycle 13.
REQ-035 Serialize wait: serialize_req=1 and rob_empty=0 for 5 cycles, then rob_empty=1 -> stallF/D/R=1 for 5 cycles, 0 on the cycle rob_empty rises, state RUN.
REQ-036 Serialize interrupted: branch_miss while in SERIAL -> flush that cycle, then RECOVER, with no SERIAL stall afterwards.
REQ-037 Backpressure watchdog (STALL_LIMIT=8): iq_full held for 8 cycles -> stuck=1 on the 9th cycle; iq_full drops -> stuck=0 the following cycle.
REQ-038 Reset mid-operation: reset asserted during SERIAL -> flushes=1 and stalls=0 during reset; state=RUN and busy=0 after it.
